drrip_cache_ctrl: RTL
=====================

DRRIP_CACHE_CTRL -- requirements
Module: drrip_cache_ctrl

Interface
REQ-001 SHALL have parameter NUM_WAYS, default 16: ways per set.
REQ-002 SHALL have parameter NUM_SETS, default 128: sets.
REQ-003 SHALL have parameter SET_INDEX_WIDTH, default $clog2(NUM_SETS): set index width.
REQ-004 SHALL have parameter ADDR_WIDTH, default 32: request address width.
REQ-005 SHALL have parameter OFFSET_BITS, default 6: line offset bits.
REQ-006 SHALL have parameter TAG_WIDTH, default ADDR_WIDTH-SET_INDEX_WIDTH-OFFSET_BITS: tag width.
REQ-007 SHALL have parameter TIMEOUT_CYCLES, default 64: maximum miss-wait cycles.
REQ-008 SHALL have parameter STAT_BITS, default 16: statistics counter width.
REQ-009 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-010 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-011 SHALL have ports req_valid (input, 1), req_ready (output, 1) and req_addr (input, ADDR_WIDTH): lookup request.
REQ-012 SHALL have ports resp_valid (output, 1) and resp_ready (input, 1): response handshake.
REQ-013 SHALL have response fields, all outputs: resp_hit (1), resp_way (4), resp_err (1), resp_evict_valid (1), resp_evict_tag (TAG_WIDTH).
REQ-014 SHALL have policy-side outputs: pol_valid (1), pol_set_index (SET_INDEX_WIDTH), pol_access_way (4), pol_hit (1), pol_miss (1).
REQ-015 SHALL have policy-side inputs: pol_victim_way (4) and pol_victim_ready (1).
REQ-016 SHALL have statistics outputs hit_count and miss_count, each STAT_BITS wide.

Function
REQ-017 SHALL hold per-way tag and valid bit storage for every set.
REQ-018 SHALL decode addresses as set = addr[OFFSET_BITS +: SET_INDEX_WIDTH] and tag = addr[ADDR_WIDTH-1 -: TAG_WIDTH].
REQ-019 SHALL implement FSM states IDLE, LOOKUP, HIT_NOTIFY, MISS_WAIT, FILL and RESP.
REQ-020 SHALL assert req_ready only in IDLE; on req_valid&&req_ready it SHALL capture the address and go to LOOKUP.
REQ-021 SHALL, in LOOKUP (one cycle), compare the tag against all valid ways; hit selects the lowest matching way.
REQ-022 SHALL go to HIT_NOTIFY on hit and to MISS_WAIT on miss.
REQ-023 SHALL, in HIT_NOTIFY, drive pol_valid=1, pol_hit=1 and pol_access_way=the hit way for exactly one cycle, then go to RESP.
REQ-024 SHALL, in MISS_WAIT, drive pol_miss = pol_valid = !pol_victim_ready, combinationally gated, so the policy never sees a second miss.
REQ-025 SHALL, in MISS_WAIT, sample pol_victim_way on the edge where pol_victim_ready=1 and go to FILL.
REQ-026 SHALL drive pol_set_index from the captured set for the whole transaction and hold it in IDLE.
REQ-027 SHALL, in FILL (one cycle), latch the victim's old valid/tag into resp_evict_valid/resp_evict_tag, then write the new tag with valid=1.
REQ-028 SHALL increment a miss-wait counter each MISS_WAIT cycle.
REQ-029 SHALL, when that counter reaches TIMEOUT_CYCLES, go to RESP with resp_err=1, resp_evict_valid=0 and no fill; a late pol_victim_ready is then ignored.
REQ-030 SHALL, in RESP, hold resp_valid=1 with all resp_* stable until resp_ready=1, then go to IDLE.
REQ-031 SHALL set resp_way to the hit way or filled way, and resp_hit to the lookup result.
REQ-032 SHALL give hit latency: resp_valid high 3 edges after the acceptance edge.
REQ-033 SHALL give miss latency: resp_valid high 2 edges after the edge sampling pol_victim_ready=1.
REQ-034 SHALL increment hit_count or miss_count once per LOOKUP, saturating at all-ones; a timeout still counts as a miss.
REQ-035 SHALL drive pol_* outputs to 0 in every state not named above, except pol_set_index.

Reset
REQ-036 SHALL, on asserted rst at any time (including mid-MISS_WAIT), immediately force IDLE.
REQ-037 SHALL, on reset, clear all valid bits, counters and miss-wait count.
REQ-038 SHALL, on reset, zero all outputs except req_ready, which becomes 1 after rst deasserts.

Verification
REQ-039 SHALL cover: after reset, req 0x00001040 (set 65, tag 0), stub victim_way=3 -> pol_miss high until ready, resp_hit=0, resp_way=3, evict_valid=0, miss_count=1.
REQ-040 SHALL cover: same address again -> pol_hit one-cycle pulse with access_way=3, resp_hit=1, resp_way=3, hit_count=1, resp_valid 3 edges after accept.
REQ-041 SHALL cover: 0x5040 filled to way 5 (tag 2), then 0x7040 with stub victim 5 -> evict_valid=1, evict_tag=0x2, resp_way=5.
REQ-042 SHALL cover: stub never asserts ready -> resp_err=1 after 64 MISS_WAIT cycles, pol_miss low, and a re-request still misses.
REQ-043 SHALL cover: resp_ready low 10 cycles -> resp fields stable, req_ready=0; accepted one edge after resp_ready=1.
REQ-044 SHALL cover: rst pulsed during MISS_WAIT -> outputs 0 without a clock edge, and a previously filled address misses afterwards.

Source files
------------

// File: rtl/drrip_cache_ctrl.sv
// -----------------------------------------------------------------------------
// drrip_cache_ctrl
// Tag/valid lookup controller for a set-associative cache whose replacement
// decisions come from an external policy block (e.g. DRRIP). Each request is
// looked up; a hit notifies the policy of the accessed way, a miss asks the
// policy for a victim, installs the new tag there and reports what was evicted.
//
// Ports
//   clk, rst            : clock, asynchronous active-high reset
//   req_valid/req_ready : request handshake, req_addr is the lookup address
//   resp_valid/ready    : response handshake
//   resp_hit, resp_way  : lookup result and the hit or filled way
//   resp_err            : policy did not supply a victim in time (no fill)
//   resp_evict_valid/tag: previous contents of the filled way
//   pol_valid/pol_hit/pol_miss/pol_access_way/pol_set_index : policy notify
//   pol_victim_way/pol_victim_ready : victim choice returned by the policy
//   hit_count/miss_count: saturating lookup statistics
// -----------------------------------------------------------------------------
module drrip_cache_ctrl #(
   parameter int NUM_WAYS        = 16,
   parameter int NUM_SETS        = 128,
   parameter int SET_INDEX_WIDTH = $clog2(NUM_SETS),
   parameter int ADDR_WIDTH      = 32,
   parameter int OFFSET_BITS     = 6,
   parameter int TAG_WIDTH       = ADDR_WIDTH - SET_INDEX_WIDTH - OFFSET_BITS,
   parameter int TIMEOUT_CYCLES  = 64,
   parameter int STAT_BITS       = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       req_valid,
   output logic                       req_ready,
   input  logic [ADDR_WIDTH-1:0]      req_addr,
   output logic                       resp_valid,
   input  logic                       resp_ready,
   output logic                       resp_hit,
   output logic [3:0]                 resp_way,
   output logic                       resp_err,
   output logic                       resp_evict_valid,
   output logic [TAG_WIDTH-1:0]       resp_evict_tag,
   output logic                       pol_valid,
   output logic [SET_INDEX_WIDTH-1:0] pol_set_index,
   output logic [3:0]                 pol_access_way,
   output logic                       pol_hit,
   output logic                       pol_miss,
   input  logic [3:0]                 pol_victim_way,
   input  logic                       pol_victim_ready,
   output logic [STAT_BITS-1:0]       hit_count,
   output logic [STAT_BITS-1:0]       miss_count
);

   localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [2:0] S_IDLE       = 3'd0;
   localparam logic [2:0] S_LOOKUP     = 3'd1;
   localparam logic [2:0] S_HIT_NOTIFY = 3'd2;
   localparam logic [2:0] S_MISS_WAIT  = 3'd3;
   localparam logic [2:0] S_FILL       = 3'd4;
   localparam logic [2:0] S_RESP       = 3'd5;

   logic [2:0]                 state_r;
   logic [SET_INDEX_WIDTH-1:0] set_r;
   logic [TAG_WIDTH-1:0]       tag_r;
   logic [3:0]                 way_r;      // hit way, later the victim way
   logic [WAIT_W-1:0]          wait_cnt_r;
   logic [NUM_WAYS-1:0]        valid_r   [NUM_SETS];
   logic [TAG_WIDTH-1:0]       tag_mem_r [NUM_SETS][NUM_WAYS];

   logic       hit_s;
   logic [3:0] hit_way_s;
   logic       timeout_s;
   logic       unused_s;

   assign unused_s = ^req_addr[OFFSET_BITS-1:0];

   // Tag compare across the captured set; scanning downward leaves the lowest matching way.
   always_comb begin
      hit_s     = 1'b0;
      hit_way_s = 4'd0;
      for (int w = NUM_WAYS - 1; w >= 0; w--) begin
         if (valid_r[set_r][w] && (tag_mem_r[set_r][w] == tag_r)) begin
            hit_s     = 1'b1;
            hit_way_s = 4'(w);
         end else begin
            hit_s     = hit_s;
            hit_way_s = hit_way_s;
         end
      end
   end

   // Last permitted miss-wait cycle: this one is the TIMEOUT_CYCLES-th.
   assign timeout_s = (wait_cnt_r == WAIT_W'(TIMEOUT_CYCLES - 1));

   // Policy-side notifications; the miss request drops combinationally once the
   // victim is offered so the policy can never see the same miss twice.
   assign pol_hit        = (state_r == S_HIT_NOTIFY);
   assign pol_miss       = (state_r == S_MISS_WAIT) && !pol_victim_ready;
   assign pol_valid      = pol_hit || pol_miss;
   assign pol_access_way = pol_hit ? way_r : 4'd0;
   assign pol_set_index  = set_r;
   assign req_ready      = (state_r == S_IDLE) && !rst;

   // Transaction FSM and registered response fields.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r          <= S_IDLE;
         set_r            <= {SET_INDEX_WIDTH{1'b0}};
         tag_r            <= {TAG_WIDTH{1'b0}};
         way_r            <= 4'd0;
         wait_cnt_r       <= {WAIT_W{1'b0}};
         resp_valid       <= 1'b0;
         resp_hit         <= 1'b0;
         resp_way         <= 4'd0;
         resp_err         <= 1'b0;
         resp_evict_valid <= 1'b0;
         resp_evict_tag   <= {TAG_WIDTH{1'b0}};
      end else begin
         case (state_r)
            S_IDLE: begin
               if (req_valid && req_ready) begin
                  set_r            <= req_addr[OFFSET_BITS +: SET_INDEX_WIDTH];
                  tag_r            <= req_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
                  resp_hit         <= 1'b0;
                  resp_way         <= 4'd0;
                  resp_err         <= 1'b0;
                  resp_evict_valid <= 1'b0;
                  resp_evict_tag   <= {TAG_WIDTH{1'b0}};
                  state_r          <= S_LOOKUP;
               end else begin
                  state_r <= S_IDLE;
               end
            end
            S_LOOKUP: begin
               resp_hit   <= hit_s;
               wait_cnt_r <= {WAIT_W{1'b0}};
               if (hit_s) begin
                  way_r    <= hit_way_s;
                  resp_way <= hit_way_s;
                  state_r  <= S_HIT_NOTIFY;
               end else begin
                  state_r <= S_MISS_WAIT;
               end
            end
            S_HIT_NOTIFY: begin
               resp_valid <= 1'b1;
               state_r    <= S_RESP;
            end
            S_MISS_WAIT: begin
               wait_cnt_r <= wait_cnt_r + {{(WAIT_W-1){1'b0}}, 1'b1};
               if (pol_victim_ready) begin
                  way_r   <= pol_victim_way;
                  state_r <= S_FILL;
               end else if (timeout_s) begin
                  resp_err         <= 1'b1;
                  resp_evict_valid <= 1'b0;
                  resp_valid       <= 1'b1;
                  state_r          <= S_RESP;
               end else begin
                  state_r <= S_MISS_WAIT;
               end
            end
            S_FILL: begin
               resp_evict_valid <= valid_r[set_r][way_r];
               resp_evict_tag   <= tag_mem_r[set_r][way_r];
               resp_way         <= way_r;
               resp_valid       <= 1'b1;
               state_r          <= S_RESP;
            end
            S_RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  state_r    <= S_IDLE;
               end else begin
                  state_r <= S_RESP;
               end
            end
            default: begin
               resp_valid <= 1'b0;
               state_r    <= S_IDLE;
            end
         endcase
      end
   end

   // Valid bits: cleared by reset, set when a way is filled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s < NUM_SETS; s++) begin
            valid_r[s] <= {NUM_WAYS{1'b0}};
         end
      end else if (state_r == S_FILL) begin
         valid_r[set_r][way_r] <= 1'b1;
      end
   end

   // Tag storage needs no reset: stale tags are masked by their valid bits.
   always_ff @(posedge clk) begin
      if (state_r == S_FILL) begin
         tag_mem_r[set_r][way_r] <= tag_r;
      end
   end

   // Saturating hit/miss statistics, one update per lookup (timeouts count as misses).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hit_count  <= {STAT_BITS{1'b0}};
         miss_count <= {STAT_BITS{1'b0}};
      end else if (state_r == S_LOOKUP) begin
         if (hit_s) begin
            if (hit_count != {STAT_BITS{1'b1}}) begin
               hit_count <= hit_count + {{(STAT_BITS-1){1'b0}}, 1'b1};
            end
         end else begin
            if (miss_count != {STAT_BITS{1'b1}}) begin
               miss_count <= miss_count + {{(STAT_BITS-1){1'b0}}, 1'b1};
            end
         end
      end
   end

endmodule
